// File: rtl/frame_scheduler.sv
// frame_scheduler: paces frames from a free-running tick counter and runs the
// clear, walls and crosshair engines in that order through their start/done
// handshakes. It also owns the single VGA adapter write port and forwards the
// pixel stream of whichever engine is currently selected.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | disabled; frame counter held at 0
// WAIT_TICK  | frame finished early; waiting for the next frame tick
// START_CK   | one-cycle start pulse to engine K (0 clear, 1 walls, 2 crosshair)
// RUN_CK     | engine K running; waiting for cK_done
// FRAME_END  | frame_done pulse; pick next frame, wait for a tick, or go idle
module frame_scheduler #(
    parameter int unsigned FRAME_TICKS = 833333,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        c0_start,
    output logic        c1_start,
    output logic        c2_start,
    input  logic        c0_done,
    input  logic        c1_done,
    input  logic        c2_done,
    input  logic [7:0]  c0_x,
    input  logic [6:0]  c0_y,
    input  logic [17:0] c0_colour,
    input  logic        c0_write,
    input  logic [7:0]  c1_x,
    input  logic [6:0]  c1_y,
    input  logic [17:0] c1_colour,
    input  logic        c1_write,
    input  logic [7:0]  c2_x,
    input  logic [6:0]  c2_y,
    input  logic [17:0] c2_colour,
    input  logic        c2_write,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [17:0] vga_colour,
    output logic        vga_write,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_START_C0,
        S_RUN_C0,
        S_START_C1,
        S_RUN_C1,
        S_START_C2,
        S_RUN_C2,
        S_FRAME_END
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(FRAME_TICKS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [2:0]         start_q;
    logic               busy_q;
    logic               frame_done_q;
    logic [7:0]         vga_x_q;
    logic [6:0]         vga_y_q;
    logic [17:0]        vga_colour_q;
    logic               vga_write_q;

    logic               tick;
    logic               mux_valid;
    logic [7:0]         mux_x;
    logic [6:0]         mux_y;
    logic [17:0]        mux_colour;
    logic               mux_write;

    function automatic logic is_busy(input state_t s);
        return !(s == S_IDLE || s == S_WAIT_TICK);
    endfunction

    assign tick = (cnt_q == TICK_LAST);

    // Next state, frame counter and tick/pending/overrun bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == S_IDLE || tick) ? '0 : cnt_q + CNT_W'(1);
        pending_d = pending_q;
        overrun_d = overrun_q;
        // A tick landing mid-frame queues one frame; a second one is an overrun.
        if (tick && is_busy(state_q)) begin
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end
        case (state_q)
            S_IDLE: begin
                pending_d = 1'b0;
                if (enable) begin
                    state_d = S_START_C0;
                end
            end
            S_WAIT_TICK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (tick || pending_q) begin
                    state_d   = S_START_C0;
                    pending_d = 1'b0;
                end
            end
            S_START_C0: state_d = S_RUN_C0;
            S_RUN_C0:   if (c0_done) state_d = S_START_C1;
            S_START_C1: state_d = S_RUN_C1;
            S_RUN_C1:   if (c1_done) state_d = S_START_C2;
            S_START_C2: state_d = S_RUN_C2;
            S_RUN_C2:   if (c2_done) state_d = S_FRAME_END;
            S_FRAME_END: begin
                // pending_d already includes a tick arriving in this cycle,
                // so a coinciding tick starts the next frame with no wait.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (pending_d) begin
                    state_d = S_START_C0;
                end else begin
                    state_d = S_WAIT_TICK;
                end
                pending_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel select: the engine being started or run owns the VGA port.
    always_comb begin
        mux_valid  = 1'b1;
        mux_x      = c0_x;
        mux_y      = c0_y;
        mux_colour = c0_colour;
        mux_write  = c0_write;
        case (state_q)
            S_START_C0, S_RUN_C0: begin
                mux_x      = c0_x;
                mux_y      = c0_y;
                mux_colour = c0_colour;
                mux_write  = c0_write;
            end
            S_START_C1, S_RUN_C1: begin
                mux_x      = c1_x;
                mux_y      = c1_y;
                mux_colour = c1_colour;
                mux_write  = c1_write;
            end
            S_START_C2, S_RUN_C2: begin
                mux_x      = c2_x;
                mux_y      = c2_y;
                mux_colour = c2_colour;
                mux_write  = c2_write;
            end
            default: mux_valid = 1'b0;
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            start_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            start_q      <= {state_d == S_START_C2, state_d == S_START_C1, state_d == S_START_C0};
            busy_q       <= is_busy(state_d);
            frame_done_q <= (state_d == S_FRAME_END);
            vga_write_q  <= mux_valid & mux_write;
            if (mux_valid) begin
                vga_x_q      <= mux_x;
                vga_y_q      <= mux_y;
                vga_colour_q <= mux_colour;
            end
        end
    end

    assign c0_start   = start_q[0];
    assign c1_start   = start_q[1];
    assign c2_start   = start_q[2];
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_write  = vga_write_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: engine models with programmable latency, a
// frame-level reference model checked every cycle, a table of frame timings,
// and directed sequences for the multi-cycle corner cases.
module tb_frame_scheduler;

    localparam int FT = 50;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        c0_start, c1_start, c2_start;
    logic        edone [3];
    logic [7:0]  ex    [3];
    logic [6:0]  ey    [3];
    logic [17:0] ec    [3];
    logic        ew    [3];
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;
    logic        busy, frame_done, overrun;

    frame_scheduler #(.FRAME_TICKS(FT), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .c0_start(c0_start), .c1_start(c1_start), .c2_start(c2_start),
        .c0_done(edone[0]), .c1_done(edone[1]), .c2_done(edone[2]),
        .c0_x(ex[0]), .c0_y(ey[0]), .c0_colour(ec[0]), .c0_write(ew[0]),
        .c1_x(ex[1]), .c1_y(ey[1]), .c1_colour(ec[1]), .c1_write(ew[1]),
        .c2_x(ex[2]), .c2_y(ey[2]), .c2_colour(ec[2]), .c2_write(ew[2]),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat  [3];
    int ecnt [3];
    bit spur [3];
    int pix_mode = 0;

    // Reference model: which engine owns the frame (-1 idle, -2 waiting for
    // a tick, 0..2 engine, 3 frame end), whether it is in its start cycle,
    // the frame counter and the queued-frame / overrun flags.
    int          m_st;
    bit          m_starting;
    int          m_cnt;
    bit          m_pend, m_ovr;
    logic        m_vw;
    logic [7:0]  m_vx;
    logic [6:0]  m_vy;
    logic [17:0] m_vc;

    // Inputs as they were during the cycle just ending.
    bit          p_rst, p_en;
    logic        p_done [3];
    logic [7:0]  p_x [3];
    logic [6:0]  p_y [3];
    logic [17:0] p_c [3];
    logic        p_w [3];

    typedef struct {
        int lat;
        int s0;
        int s1;
        int s2;
        int fd;
        int s0b;
    } vec_t;
    vec_t vecs [4];

    int f0, f1, f2, ffd, f0b, nfd, nc0, n100, first100, n5, bad5;

    function automatic logic cs(input int k);
        case (k)
            0:       return c0_start;
            1:       return c1_start;
            default: return c2_start;
        endcase
    endfunction

    function automatic logic [39:0] act_vec();
        return {c2_start, c1_start, c0_start, busy, frame_done, overrun,
                vga_write, vga_x, vga_y, vga_colour};
    endfunction

    function automatic logic [39:0] exp_vec();
        logic s0, s1, s2, b, fd;
        s0 = (m_st == 0) && m_starting;
        s1 = (m_st == 1) && m_starting;
        s2 = (m_st == 2) && m_starting;
        b  = (m_st >= 0);
        fd = (m_st == 3);
        return {s2, s1, s0, b, fd, m_ovr, m_vw, m_vx, m_vy, m_vc};
    endfunction

    task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic model_reset();
        m_st = -1; m_starting = 0; m_cnt = 0; m_pend = 0; m_ovr = 0;
        m_vw = 0; m_vx = '0; m_vy = '0; m_vc = '0;
    endtask

    task automatic eng_clear();
        for (int k = 0; k < 3; k++) begin
            ecnt[k] = -1; edone[k] = 0; spur[k] = 0;
            ex[k] = '0; ey[k] = '0; ec[k] = '0; ew[k] = 0;
        end
    endtask

    task automatic model_advance();
        bit tick;
        if (!p_rst) begin
            model_reset();
            return;
        end
        tick = (m_cnt == FT - 1);
        if (tick && m_st >= 0) begin
            if (m_pend) m_ovr = 1;
            m_pend = 1;
        end
        if (m_st >= 0 && m_st <= 2) begin
            m_vw = p_w[m_st]; m_vx = p_x[m_st]; m_vy = p_y[m_st]; m_vc = p_c[m_st];
        end else begin
            m_vw = 0;
        end
        m_cnt = (m_st == -1 || tick) ? 0 : m_cnt + 1;
        case (m_st)
            -1: if (p_en) begin m_st = 0; m_starting = 1; m_pend = 0; end
            -2: begin
                if (!p_en) m_st = -1;
                else if (tick || m_pend) begin m_st = 0; m_starting = 1; m_pend = 0; end
            end
            3: begin
                if (!p_en) m_st = -1;
                else if (m_pend) begin m_st = 0; m_starting = 1; end
                else m_st = -2;
                m_pend = 0;
            end
            default: begin
                if (m_starting) m_starting = 0;
                else if (p_done[m_st]) begin
                    if (m_st == 2) m_st = 3;
                    else begin m_st = m_st + 1; m_starting = 1; end
                end
            end
        endcase
    endtask

    task automatic drive_engines();
        for (int k = 0; k < 3; k++) begin
            if (cs(k)) ecnt[k] = lat[k];
            else if (ecnt[k] >= 0) ecnt[k] = ecnt[k] - 1;
            edone[k] = (ecnt[k] == 0) || spur[k];
            spur[k]  = 0;
            if (pix_mode == 0) begin
                ex[k] = 8'($urandom); ey[k] = 7'($urandom);
                ec[k] = 18'($urandom); ew[k] = 1'($urandom);
            end else if (k == 0) begin
                ex[k] = 8'd0; ey[k] = 7'd0; ec[k] = 18'd0; ew[k] = 0;
            end else if (k == 1) begin
                ex[k] = 8'd100; ey[k] = 7'd60; ec[k] = 18'h3FFFF;
                ew[k] = (ecnt[1] < lat[1]) && (ecnt[1] >= lat[1] - 3);
            end else begin
                ex[k] = 8'd5; ey[k] = 7'd7; ec[k] = 18'h1; ew[k] = 1;
            end
        end
    endtask

    task automatic step();
        p_rst = reset; p_en = enable;
        for (int k = 0; k < 3; k++) begin
            p_done[k] = edone[k]; p_x[k] = ex[k]; p_y[k] = ey[k];
            p_c[k] = ec[k]; p_w[k] = ew[k];
        end
        @(posedge clock);
        #1;
        cyc++;
        model_advance();
        chk("cycle_outputs", act_vec(), exp_vec());
        drive_engines();
    endtask

    task automatic run_from_reset(input int l);
        reset = 0; enable = 0;
        for (int k = 0; k < 3; k++) lat[k] = l;
        model_reset();
        eng_clear();
        step();
        step();
        enable = 1; reset = 1; cyc = 0;
    endtask

    initial begin
        vecs[0] = '{lat: 5, s0: 1, s1: 7,  s2: 13, fd: 19, s0b: 51};
        vecs[1] = '{lat: 1, s0: 1, s1: 3,  s2: 5,  fd: 7,  s0b: 51};
        vecs[2] = '{lat: 3, s0: 1, s1: 5,  s2: 9,  fd: 13, s0b: 51};
        vecs[3] = '{lat: 8, s0: 1, s1: 10, s2: 19, fd: 28, s0b: 51};

        reset = 0; enable = 0;
        for (int k = 0; k < 3; k++) lat[k] = 5;
        model_reset();
        eng_clear();
        #2;
        chk("reset_outputs", act_vec(), 40'd0);

        // Frame timing table.
        for (int i = 0; i < 4; i++) begin
            run_from_reset(vecs[i].lat);
            f0 = -1; f1 = -1; f2 = -1; ffd = -1; f0b = -1;
            repeat (60) begin
                step();
                if (c0_start) begin
                    if (f0 < 0) f0 = cyc;
                    else if (f0b < 0) f0b = cyc;
                end
                if (c1_start && f1 < 0) f1 = cyc;
                if (c2_start && f2 < 0) f2 = cyc;
                if (frame_done && ffd < 0) ffd = cyc;
            end
            chk_i("tbl_c0_start", f0, vecs[i].s0);
            chk_i("tbl_c1_start", f1, vecs[i].s1);
            chk_i("tbl_c2_start", f2, vecs[i].s2);
            chk_i("tbl_frame_done", ffd, vecs[i].fd);
            chk_i("tbl_next_c0_start", f0b, vecs[i].s0b);
        end

        // Pixel mux: walls writes x=100 for 3 cycles, crosshair always writes x=5.
        pix_mode = 1;
        run_from_reset(5);
        n100 = 0; first100 = -1; n5 = 0; bad5 = 0;
        repeat (40) begin
            step();
            if (vga_write && vga_x == 8'd100) begin
                n100++;
                if (first100 < 0) first100 = cyc;
            end
            if (vga_write && vga_x == 8'd5) begin
                n5++;
                if (cyc < 14 || cyc > 19) bad5++;
            end
        end
        chk_i("mux_walls_writes", n100, 3);
        chk_i("mux_walls_first", first100, 9);
        chk_i("mux_cross_writes", n5, 6);
        chk_i("mux_cross_outside", bad5, 0);
        pix_mode = 0;

        // Overrun: frames far longer than the tick period.
        run_from_reset(40);
        while (cyc < 100) step();
        chk("ovr_before_second_tick", {39'd0, overrun}, 40'd0);
        step();
        chk("ovr_after_second_tick", {39'd0, overrun}, 40'd1);
        while (cyc < 124) step();
        chk("ovr_frame_done", {39'd0, frame_done}, 40'd1);
        step();
        chk("ovr_immediate_restart", {39'd0, c0_start}, 40'd1);

        // Enable drop during RUN_C1.
        run_from_reset(5);
        while (cyc < 9) step();
        chk("drop_busy_in_c1", {39'd0, busy}, 40'd1);
        enable = 0;
        f2 = -1; nfd = 0; nc0 = 0;
        while (cyc < 40) begin
            step();
            if (c2_start && f2 < 0) f2 = cyc;
            if (frame_done) nfd++;
            if (c0_start) nc0++;
        end
        chk_i("drop_c2_start", f2, 13);
        chk_i("drop_frame_done_count", nfd, 1);
        chk_i("drop_no_restart", nc0, 0);
        chk("drop_idle_busy", {39'd0, busy}, 40'd0);
        enable = 1;
        f0 = -1;
        for (int k = 1; k <= 2; k++) begin
            step();
            if (c0_start && f0 < 0) f0 = k;
        end
        chk_i("reenable_c0_within_2", int'(f0 >= 1 && f0 <= 2), 1);

        // Asynchronous reset mid-RUN_C2.
        run_from_reset(5);
        while (cyc < 15) step();
        chk("pre_reset_busy", {39'd0, busy}, 40'd1);
        #3;
        reset = 0;
        #1;
        chk("async_reset_outputs", act_vec(), 40'd0);
        model_reset();
        eng_clear();
        step();
        step();
        reset = 1; enable = 1; cyc = 0;
        f0 = -1;
        for (int k = 1; k <= 2; k++) begin
            step();
            if (c0_start && f0 < 0) f0 = k;
        end
        chk_i("reset_release_c0_within_2", int'(f0 >= 1 && f0 <= 2), 1);

        // Spurious c2_done during RUN_C0.
        run_from_reset(5);
        while (cyc < 3) step();
        spur[2] = 1;
        step();
        step();
        chk("spur_still_busy", {39'd0, busy}, 40'd1);
        chk("spur_no_c1_start", {39'd0, c1_start}, 40'd0);
        f1 = -1; f2 = -1;
        while (cyc < 16) begin
            step();
            if (c1_start && f1 < 0) f1 = cyc;
            if (c2_start && f2 < 0) f2 = cyc;
        end
        chk_i("spur_c1_start", f1, 7);
        chk_i("spur_c2_start", f2, 13);

        // Randomized run against the reference model.
        pix_mode = 0;
        run_from_reset(3);
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                for (int k = 0; k < 3; k++) lat[k] = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 31) == 0) spur[k] = 1;
            end
            if (n == 1000 || n == 2200) begin
                #3;
                reset = 0;
                #1;
                chk("rand_async_reset", act_vec(), 40'd0);
                model_reset();
                eng_clear();
                step();
                reset = 1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
